branch_target_predictor: RTL
============================

# branch_target_predictor

Parametrised direct-mapped branch target buffer with per-entry saturating direction counters, sitting beside the fetch stage of the pipelined MIPS datapath. Fetch presents the current PC and receives a taken/not-taken prediction plus next-fetch address in the same cycle. Execute reports each resolved branch one or more cycles later to train the table. Saturating accuracy counters are kept for performance evaluation.

## Interface
- ENTRIES, 8: table depth; power of two, at least 2. IDX_W = log2(ENTRIES).
- CTR_W, 2: direction counter width, at least 1.
- CNT_W, 16: width of the accuracy statistics counters.
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous reset, active low
- pc  in  32  fetch address (word_t), word aligned
- pred_taken  out  1  predict taken
- pred_target  out  32  next fetch address: BTB target when pred_taken, else pc+4
- upd_valid  in  1  a branch resolved in EX this cycle
- upd_pc  in  32  address of the resolved branch
- upd_taken  in  1  actual direction
- upd_target  in  32  actual taken target
- upd_pred_taken  in  1  direction that was predicted for this branch
- correct_cnt  out  CNT_W  correctly predicted resolutions, saturating
- wrong_cnt  out  CNT_W  mispredicted resolutions, saturating

## Operation
- Address fields: index = addr[IDX_W+1:2]; tag = addr[31:IDX_W+2]. Bits [1:0] are ignored.
- Each entry holds valid, tag, a 32-bit target, and a CTR_W counter ctr.
- Counter encoding: 0 = strong not-taken, 2^CTR_W-1 = strong taken. The MSB set means predict taken.
- Lookup is combinational. hit = valid[index] and tag match. pred_taken = hit and ctr[MSB]. pred_target = pred_taken ? target : pc+4, with wrap-around modulo 2^32.
- Update is registered on CLK when upd_valid = 1:
  - Entry hit and taken: ctr increments, saturating at max. Target is overwritten with upd_target.
  - Entry hit and not taken: ctr decrements, saturating at 0. Target is unchanged.
  - Miss and taken: allocate the entry. Set valid = 1, tag from upd_pc, target = upd_target, ctr = 2^(CTR_W-1) (weak taken). This replaces any entry with a different tag.
  - Miss and not taken: no table change.
- Statistics, updated when upd_valid = 1:
  - If upd_pred_taken == upd_taken, correct_cnt increments; otherwise wrong_cnt increments.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
- Simultaneous lookup and update to the same index: lookup returns the pre-update state. There is no bypass; the new state is visible the following cycle.
- upd_valid = 0: nothing changes.

## Timing
- Lookup latency is 0 cycles (combinational from pc).
- An update is visible to lookup 1 cycle after the sampling edge.
- Reset (nRST low, asynchronous):
  - All valid = 0, all ctr = 2^(CTR_W-1)-1 (weak not-taken), all targets = 0.
  - correct_cnt = 0, wrong_cnt = 0.
  - Consequently pred_taken = 0 and pred_target = pc+4 while in reset and after it.
- Reset asserted mid-operation clears all state immediately, regardless of upd_valid. Updates present while nRST is low are discarded.
- Reset deassertion is synchronised by the surrounding design. The first update is accepted on the first rising edge with nRST high.

## Test plan
- Reset, then pc = 0x00000040 -> pred_taken = 0, pred_target = 0x00000044, correct_cnt = wrong_cnt = 0.
- Update upd_pc = 0x40, taken, target 0x100, upd_pred_taken = 0 -> next cycle pc = 0x40 gives pred_taken = 1, pred_target = 0x100; wrong_cnt = 1.
- Two not-taken updates to 0x40 after allocation (ctr 2->1->0) -> pred_taken = 0 after the first; a further not-taken update holds ctr at 0; three taken updates are needed to reach ctr 3; one extra taken update saturates.
- Alias check with ENTRIES = 8: allocate 0x40, then taken update to 0x60 (same index, different tag) -> pc = 0x40 misses (pred_target = 0x44); pc = 0x60 hits.
- Same-cycle update and lookup on 0x80 (first allocation) -> pred_taken = 0 that cycle, 1 the next. pc = 0xFFFFFFFC miss -> pred_target = 0x00000000.
- CNT_W = 2, five correct updates -> correct_cnt holds at 3. nRST pulsed mid-stream with upd_valid = 1 -> all counters 0, table empty.

Source files
------------

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Combinational lookup from the fetch PC; registered training from resolved branches.
module branch_target_predictor #(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [31:0]      pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  output logic [CNT_W-1:0] correct_cnt,
  output logic [CNT_W-1:0] wrong_cnt
);

  localparam int unsigned IDX_W       = $clog2(ENTRIES);
  localparam int unsigned TAG_W       = 30 - IDX_W;
  localparam int unsigned CtrWeakTInt = 1 << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CtrWeakT  = CTR_W'(CtrWeakTInt);
  localparam logic [CTR_W-1:0] CtrWeakNt = CTR_W'(CtrWeakTInt - 1);
  localparam logic [CTR_W-1:0] CtrMax    = {CTR_W{1'b1}};

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [CTR_W-1:0] r_ctr    [ENTRIES];
  logic [CNT_W-1:0] r_correct;
  logic [CNT_W-1:0] r_wrong;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_u_hit;
  logic [CTR_W-1:0] w_ctr_cur;
  logic [CTR_W-1:0] w_ctr_nxt;
  logic             w_wr_ctr;
  logic             w_wr_tgt;
  logic             w_alloc;
  logic             w_unused_bits;

  // Byte-offset bits of word-aligned addresses carry no information.
  assign w_unused_bits = ^{pc[1:0], upd_pc[1:0]};

  // Lookup path: reads pre-update state, no bypass from the update port.
  assign w_idx       = pc[IDX_W+1:2];
  assign w_tag       = pc[31:IDX_W+2];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign pred_taken  = w_hit && r_ctr[w_idx][CTR_W-1];
  assign pred_target = pred_taken ? r_target[w_idx] : (pc + 32'd4);

  assign w_u_idx   = upd_pc[IDX_W+1:2];
  assign w_u_tag   = upd_pc[31:IDX_W+2];
  assign w_u_hit   = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_ctr_cur = r_ctr[w_u_idx];

  always_comb begin
    w_ctr_nxt = w_ctr_cur;
    w_wr_ctr  = 1'b0;
    w_wr_tgt  = 1'b0;
    w_alloc   = 1'b0;
    if (upd_valid) begin
      if (w_u_hit) begin
        w_wr_ctr = 1'b1;
        if (upd_taken) begin
          w_wr_tgt = 1'b1;
          if (w_ctr_cur != CtrMax) w_ctr_nxt = w_ctr_cur + CTR_W'(1);
        end else begin
          if (w_ctr_cur != '0) w_ctr_nxt = w_ctr_cur - CTR_W'(1);
        end
      end else if (upd_taken) begin
        w_alloc = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CtrWeakNt;
      end
    end else begin
      if (w_alloc) begin
        r_valid[w_u_idx]  <= 1'b1;
        r_tag[w_u_idx]    <= w_u_tag;
        r_target[w_u_idx] <= upd_target;
        r_ctr[w_u_idx]    <= CtrWeakT;
      end else if (w_wr_ctr) begin
        r_ctr[w_u_idx] <= w_ctr_nxt;
        if (w_wr_tgt) r_target[w_u_idx] <= upd_target;
      end
    end
  end

  // Accuracy statistics saturate rather than wrap.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_correct <= '0;
      r_wrong   <= '0;
    end else if (upd_valid) begin
      if (upd_pred_taken == upd_taken) begin
        if (r_correct != {CNT_W{1'b1}}) r_correct <= r_correct + CNT_W'(1);
      end else begin
        if (r_wrong != {CNT_W{1'b1}}) r_wrong <= r_wrong + CNT_W'(1);
      end
    end
  end

  assign correct_cnt = r_correct;
  assign wrong_cnt   = r_wrong;

endmodule
